// File: rtl/lna_power_pkg.sv
// Shared types and constants for the LNA bias/supply power sequencer.
package lna_power_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_NEG_RAMP,
    ST_NEG_SETTLE,
    ST_POS_RAMP,
    ST_POS_SETTLE,
    ST_ON,
    ST_DROP_POS,
    ST_FAULT
  } seq_state_t;

  localparam logic [1:0] FAULT_NONE        = 2'd0;
  localparam logic [1:0] FAULT_VMINUS      = 2'd1;
  localparam logic [1:0] FAULT_VPLUS       = 2'd2;
  localparam logic [1:0] FAULT_OVERCURRENT = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lna_power_sequencer_seq_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lna_power_sequencer.sv
// Brings up V-, then V+, then the LNA supply; shuts down in reverse and latches rail/overcurrent faults.
module lna_power_sequencer
  import lna_power_pkg::*;
#(
  parameter int SETTLE_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES   = 5000,
  parameter int FAULT_FILTER     = 4,
  parameter int DISCHARGE_CYCLES = 2000
) (
  input  logic       Clock100Mhz,
  input  logic       Reset,
  input  logic       PowerRequest,
  input  logic       VminusGood,
  input  logic       VplusGood,
  input  logic       LnaOverCurrent,
  input  logic       ClearFault,
  output logic       EnableVminus,
  output logic       EnableVplus,
  output logic       EnableLna,
  output logic       PowerReady,
  output logic       FaultLatched,
  output logic [1:0] FaultCode
);

  localparam int TIMER_W  = $clog2(max3(SETTLE_CYCLES, TIMEOUT_CYCLES, DISCHARGE_CYCLES) + 1);
  localparam int FILTER_W = $clog2(FAULT_FILTER + 1);

  // A state lasting N cycles is loaded with N-1 so done is seen in its last cycle.
  localparam logic [TIMER_W-1:0]  SETTLE_LOAD    = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  TIMEOUT_LOAD   = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  DISCHARGE_LOAD = TIMER_W'(DISCHARGE_CYCLES - 1);
  localparam logic [FILTER_W-1:0] FILTER_LIMIT   = FILTER_W'(FAULT_FILTER);

  seq_state_t          state;
  seq_state_t          next_state;
  logic [1:0]          next_code;
  logic                next_latched;
  logic [1:0]          detected;
  logic [FILTER_W-1:0] oc_count;
  logic [FILTER_W-1:0] next_oc;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_done;

  seq_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (Clock100Mhz),
    .reset     (Reset),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  // Fault checks come first in every state, so a fault beats a simultaneous power-down.
  always_comb begin
    next_state   = state;
    next_code    = FaultCode;
    next_latched = FaultLatched;
    detected     = FAULT_NONE;
    next_oc      = '0;

    case (state)
      ST_OFF: begin
        if (PowerRequest && !FaultLatched) next_state = ST_NEG_RAMP;
      end
      ST_NEG_RAMP: begin
        if (!VminusGood && timer_done) detected = FAULT_VMINUS;
        else if (!PowerRequest)        next_state = ST_DROP_POS;
        else if (VminusGood)           next_state = ST_NEG_SETTLE;
      end
      ST_NEG_SETTLE: begin
        if (!VminusGood)        detected = FAULT_VMINUS;
        else if (!PowerRequest) next_state = ST_DROP_POS;
        else if (timer_done)    next_state = ST_POS_RAMP;
      end
      ST_POS_RAMP: begin
        if (!VminusGood)                    detected = FAULT_VMINUS;
        else if (!VplusGood && timer_done)  detected = FAULT_VPLUS;
        else if (!PowerRequest)             next_state = ST_DROP_POS;
        else if (VplusGood)                 next_state = ST_POS_SETTLE;
      end
      ST_POS_SETTLE: begin
        if (!VminusGood)        detected = FAULT_VMINUS;
        else if (!VplusGood)    detected = FAULT_VPLUS;
        else if (!PowerRequest) next_state = ST_DROP_POS;
        else if (timer_done)    next_state = ST_ON;
      end
      ST_ON: begin
        if (LnaOverCurrent) next_oc = (oc_count == FILTER_LIMIT) ? oc_count : oc_count + 1'b1;
        if (!VminusGood)                  detected = FAULT_VMINUS;
        else if (!VplusGood)              detected = FAULT_VPLUS;
        else if (next_oc == FILTER_LIMIT) detected = FAULT_OVERCURRENT;
        else if (!PowerRequest)           next_state = ST_DROP_POS;
      end
      ST_DROP_POS: begin
        if (timer_done) next_state = FaultLatched ? ST_FAULT : ST_OFF;
      end
      ST_FAULT: begin
        if (ClearFault && !PowerRequest) begin
          next_state   = ST_OFF;
          next_code    = FAULT_NONE;
          next_latched = 1'b0;
        end
      end
      default: next_state = ST_OFF;
    endcase

    // V- stays up through the discharge whenever V+ may still be charged.
    if (detected != FAULT_NONE) begin
      next_latched = 1'b1;
      if (!FaultLatched) next_code = detected;
      next_state = (state == ST_NEG_RAMP || state == ST_NEG_SETTLE) ? ST_FAULT : ST_DROP_POS;
    end

    if (next_state != ST_ON) next_oc = '0;

    timer_load  = (next_state != state);
    timer_value = '0;
    case (next_state)
      ST_NEG_RAMP, ST_POS_RAMP:     timer_value = TIMEOUT_LOAD;
      ST_NEG_SETTLE, ST_POS_SETTLE: timer_value = SETTLE_LOAD;
      ST_DROP_POS:                  timer_value = DISCHARGE_LOAD;
      default:                      timer_value = '0;
    endcase
  end

  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      state        <= ST_OFF;
      oc_count     <= '0;
      FaultCode    <= FAULT_NONE;
      FaultLatched <= 1'b0;
      EnableVminus <= 1'b0;
      EnableVplus  <= 1'b0;
      EnableLna    <= 1'b0;
      PowerReady   <= 1'b0;
    end else begin
      state        <= next_state;
      oc_count     <= next_oc;
      FaultCode    <= next_code;
      FaultLatched <= next_latched;
      EnableVminus <= (next_state inside {ST_NEG_RAMP, ST_NEG_SETTLE, ST_POS_RAMP,
                                          ST_POS_SETTLE, ST_ON, ST_DROP_POS});
      EnableVplus  <= (next_state inside {ST_POS_RAMP, ST_POS_SETTLE, ST_ON});
      EnableLna    <= (next_state == ST_ON);
      PowerReady   <= (next_state == ST_ON);
    end
  end

endmodule
